// File: rtl/div48_ins.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div48_ins                                                     |
// | Purpose  : Sequential unsigned divider, 48-bit dividend / 24-bit divisor.|
// |            Radix-2 restoring division, one quotient bit per cycle, with  |
// |            a start/ready handshake matching the 24x24 multiplier.        |
// | Ports    : clk      - rising-edge clock                                  |
// |            rst      - asynchronous active-high reset                     |
// |            start    - request, sampled only while idle                   |
// |            input0   - 48-bit dividend (sampled at accept edge)           |
// |            input1   - 24-bit divisor  (sampled at accept edge)           |
// |            ready    - result valid, held until next accepted start       |
// |            output0  - 24-bit quotient                                    |
// |            output1  - 24-bit remainder                                   |
// |            overflow - quotient exceeds 24 bits (includes divide by zero) |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module div48_ins (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] input0,
  input  logic [23:0] input1,
  output logic        ready,
  output logic [23:0] output0,
  output logic [23:0] output1,
  output logic        overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [4:0] C_LAST_CNT = 5'd23;

  logic [1:0]  r_state;
  logic [24:0] r_r;      // partial remainder
  logic [23:0] r_q;      // dividend low half shifting out, quotient shifting in
  logic [23:0] r_d;      // latched divisor
  logic [4:0]  r_cnt;
  logic        r_ovf;
  logic        r_ready;
  logic [23:0] r_quot;
  logic [23:0] r_rem;
  logic        r_overflow;

  logic [24:0] w_t;
  logic [24:0] w_d_ext;
  logic        w_ge;
  logic [24:0] w_diff;
  logic        w_unused_r_msb;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign w_t     = {r_r[23:0], r_q[23]};
  assign w_d_ext = {1'b0, r_d};
  assign w_ge    = (w_t >= w_d_ext);
  assign w_diff  = w_t - w_d_ext;

  // The remainder stays below the divisor, so its top bit never carries data
  // into the next step; it exists only to hold the pre-compare shifted value.
  assign w_unused_r_msb = r_r[24];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_r        <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_ready    <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ready <= 1'b0;
            r_d     <= input1;
            r_r     <= {1'b0, input0[47:24]};
            r_q     <= input0[23:0];
            r_cnt   <= '0;
            // Upper half not below the divisor means the quotient needs more
            // than 24 bits; a zero divisor always lands here too.
            if (input0[47:24] >= input1) begin
              r_ovf   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_ovf   <= 1'b0;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_ge) begin
            r_r <= w_diff;
            r_q <= {r_q[22:0], 1'b1};
          end else begin
            r_r <= w_t;
            r_q <= {r_q[22:0], 1'b0};
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == C_LAST_CNT) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (r_ovf) begin
            r_quot     <= 24'hFFFFFF;
            r_rem      <= '0;
            r_overflow <= 1'b1;
          end else begin
            r_quot     <= r_q;
            r_rem      <= r_r[23:0];
            r_overflow <= 1'b0;
          end
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign output0  = r_quot;
  assign output1  = r_rem;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/div48_ins.md
# div48_ins

Sequential unsigned divider: 48-bit dividend by 24-bit divisor, producing a 24-bit quotient and 24-bit remainder. It is the inverse of the team's 24x24 sequential multiplier. It closes the Newton-Raphson loop, where a 48-bit product is scaled back to 24 bits, and it serves as the golden reference divider for the iterative reciprocal path. It uses radix-2 restoring division, one quotient bit per cycle, with the same start/ready handshake as the multiplier.

## Interface
- No parameters. Widths are fixed at 48/24.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- ready  out  1  result valid; held until the next accepted start
- input0  in  48  dividend, unsigned; sampled at the accepting edge only
- input1  in  24  divisor, unsigned; sampled at the accepting edge only
- output0  out  24  quotient
- output1  out  24  remainder
- overflow  out  1  quotient does not fit in 24 bits; includes divide-by-zero

## Operation
- Reset values:
  - state = IDLE
  - ready = 0, overflow = 0
  - output0 = 0, output1 = 0
  - all internal registers 0
- Internal registers:
  - R: 25-bit partial remainder
  - Q: 24-bit shift register
  - D: 24-bit divisor latch
  - cnt: 5-bit iteration counter
- FSM states: IDLE, RUN, DONE.
- IDLE, with start = 1 at an edge (accept):
  - ready <= 0
  - D <= input1
  - R <= {1'b0, input0[47:24]}
  - Q <= input0[23:0]
  - cnt <= 0
  - Overflow check: if input0[47:24] >= input1 (this covers input1 = 0), set an internal ovf flag and go to DONE. Otherwise go to RUN.
- IDLE, with start = 0: hold. Outputs and ready are unchanged.
- RUN, each edge:
  - T = {R[23:0], Q[23]} (25 bits)
  - If T >= {1'b0, D}: R <= T - D, Q <= {Q[22:0], 1}.
  - Else: R <= T, Q <= {Q[22:0], 0}.
  - cnt <= cnt + 1. When cnt == 23, go to DONE.
- DONE, one edge, then IDLE:
  - Normal: output0 <= Q, output1 <= R[23:0], overflow <= 0.
  - ovf: output0 <= 24'hFFFFFF, output1 <= 0, overflow <= 1.
  - ready <= 1.
- start is ignored in RUN and DONE. There is no queuing.
- Outputs change only at the DONE edge or on reset. They are stable throughout a computation and are not cleared by start.
- Invariant: R < D after every RUN edge, and R[24] = 0 after a subtract.
- Normal result satisfies input0 = output0*input1 + output1, with output1 < input1.

## Timing
- Accept edge is k.
- Normal path:
  - RUN occupies edges k+1 … k+24.
  - DONE is at edge k+25.
  - ready = 1 and the results are valid after edge k+25.
  - Latency is 25 cycles.
- Overflow / divide-by-zero path: DONE is at edge k+1, so ready = 1 after edge k+1 (2-cycle latency).
- Earliest next accept is edge k+26 (normal) or k+2 (overflow). For back-to-back operation, start can be held high continuously. ready drops for the duration of each new operation.
- Operand inputs may change freely after edge k.
- rst asserted in any state, including mid-RUN:
  - Returns immediately to the reset values; the partial result is discarded.
  - After rst deasserts, the first start seen in IDLE is accepted normally.
- Critical path: one 25-bit subtract/compare plus a mux per cycle. No multiplier is instantiated.

## Test plan
- Basic division: input0 = 1000, input1 = 7, start pulsed -> ready rises exactly 25 cycles after the accept edge, with output0 = 142, output1 = 6, overflow = 0.
- Full-range operands: input0 = 48'hFFFFFE000001, input1 = 24'hFFFFFF -> output0 = 24'hFFFFFF, output1 = 0, overflow = 0.
- Overflow and divide-by-zero:
  - input0 = 48'h000001000000, input1 = 1 -> overflow = 1, output0 = 24'hFFFFFF, output1 = 0, ready after 2 cycles.
  - input1 = 0, any input0 -> same response.
- Busy behaviour:
  - Pulsing start and changing input0/input1 during RUN has no effect; the first result is unchanged.
  - Holding start high continuously gives results every 26 cycles, with ready low between them.
- Reset mid-operation: assert rst at RUN cycle 10 -> ready = 0, output0/output1/overflow = 0 immediately. A subsequent 1000/7 request then completes correctly.
- Random check: 10k random (input0, input1) pairs are compared against a reference model for quotient, remainder, overflow and latency. The set includes input1 = 1, input1 = 24'hFFFFFF, input0 = 0, and boundary values where input0[47:24] = input1 - 1.
